// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller owning the HI/LO register pair.
// Sequences fixed-latency mult/div operations and raises the HI/LO hazard stall request.
module mdu_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        abort,
   input  logic        md_use_id,
   output logic        busy,
   output logic        done,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [31:0]        a_q, a_nxt;
   logic [31:0]        b_q, b_nxt;
   // bit 1: divide, bit 0: unsigned
   logic [1:0]         op_q, op_nxt;
   logic [31:0]        hi_nxt, lo_nxt;
   logic               busy_nxt, done_nxt;

   logic               is_div, is_signed;
   logic [63:0]        ext_a, ext_b, prod;
   logic [31:0]        mag_a, mag_b, quo_mag, rem_mag;
   logic [31:0]        quo, rem;
   logic [31:0]        res_hi, res_lo;
   logic               res_wr;

   assign stall_req = md_use_id & (busy | (start & ~op[2]));

   // Result datapath, evaluated from the latched operands
   always_comb begin
      is_div    = op_q[1];
      is_signed = ~op_q[0];
      ext_a     = is_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
      ext_b     = is_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
      prod      = ext_a * ext_b;
      mag_a     = (is_signed && a_q[31]) ? (~a_q + 32'd1) : a_q;
      mag_b     = (is_signed && b_q[31]) ? (~b_q + 32'd1) : b_q;
      quo_mag   = '0;
      rem_mag   = '0;
      if (mag_b != 32'd0) begin
         quo_mag = mag_a / mag_b;
         rem_mag = mag_a % mag_b;
      end
      // Quotient truncates toward zero; remainder follows the dividend's sign
      quo    = (is_signed && (a_q[31] ^ b_q[31])) ? (~quo_mag + 32'd1) : quo_mag;
      rem    = (is_signed && a_q[31]) ? (~rem_mag + 32'd1) : rem_mag;
      res_hi = is_div ? rem : prod[63:32];
      res_lo = is_div ? quo : prod[31:0];
      res_wr = ~is_div | (b_q != 32'd0);
   end

   // Next-state and registered-output logic
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      a_nxt     = a_q;
      b_nxt     = b_q;
      op_nxt    = op_q;
      hi_nxt    = hi;
      lo_nxt    = lo;
      done_nxt  = 1'b0;
      busy_nxt  = 1'b0;

      case (state)
         S_IDLE: begin
            if (start && !abort) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     state_nxt = S_BUSY;
                     cnt_nxt   = CNT_W'(MULT_CYCLES - 1);
                     a_nxt     = rs_val;
                     b_nxt     = rt_val;
                     op_nxt    = op[1:0];
                  end
                  OP_DIV, OP_DIVU: begin
                     state_nxt = S_BUSY;
                     cnt_nxt   = CNT_W'(DIV_CYCLES - 1);
                     a_nxt     = rs_val;
                     b_nxt     = rt_val;
                     op_nxt    = op[1:0];
                  end
                  OP_MTHI: hi_nxt = rs_val;
                  OP_MTLO: lo_nxt = rs_val;
                  default: ;
               endcase
            end
         end
         S_BUSY: begin
            if (abort) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else if (cnt != '0) begin
               cnt_nxt = cnt - CNT_W'(1);
            end else begin
               state_nxt = S_IDLE;
               done_nxt  = 1'b1;
               if (res_wr) begin
                  hi_nxt = res_hi;
                  lo_nxt = res_lo;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase

      busy_nxt = (state_nxt == S_BUSY);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= '0;
         hi    <= '0;
         lo    <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         a_q   <= a_nxt;
         b_q   <= b_nxt;
         op_q  <= op_nxt;
         hi    <= hi_nxt;
         lo    <= lo_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Testbench for mdu_ctrl: directed scenarios plus random traffic against a
// cycle-level behavioural model of HI/LO, busy, done and stall_req.
module tb_mdu_ctrl;

   localparam int unsigned MC = 5;
   localparam int unsigned DC = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        abort;
   logic        md_use_id;
   logic        busy;
   logic        done;
   logic        stall_req;
   logic [31:0] hi;
   logic [31:0] lo;

   mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .abort     (abort),
      .md_use_id (md_use_id),
      .busy      (busy),
      .done      (done),
      .stall_req (stall_req),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state: remaining busy cycles and the result it will commit
   int          m_left;
   bit          m_done;
   logic [31:0] m_hi, m_lo;
   logic [31:0] p_hi, p_lo;
   bit          p_wr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_left = 0;
      m_done = 0;
      m_hi   = '0;
      m_lo   = '0;
   endtask

   task automatic model_issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint          ps;
      longint unsigned pu;
      int              sa, sb;
      p_wr = 1;
      case (o)
         3'd0: begin
            ps = longint'($signed(a)) * longint'($signed(b));
            p_hi = ps[63:32]; p_lo = ps[31:0]; m_left = MC;
         end
         3'd1: begin
            pu = {32'd0, a} * {32'd0, b};
            p_hi = pu[63:32]; p_lo = pu[31:0]; m_left = MC;
         end
         3'd2: begin
            sa = a; sb = b; m_left = DC;
            if (sb == 0) p_wr = 0;
            else if (a == 32'h8000_0000 && sb == -1) begin p_lo = 32'h8000_0000; p_hi = 0; end
            else begin p_lo = sa / sb; p_hi = sa % sb; end
         end
         3'd3: begin
            m_left = DC;
            if (b == 0) p_wr = 0;
            else begin p_lo = a / b; p_hi = a % b; end
         end
         3'd4: m_hi = a;
         3'd5: m_lo = a;
         default: ;
      endcase
   endtask

   task automatic model_edge(input bit s, input logic [2:0] o, input logic [31:0] a,
                             input logic [31:0] b, input bit ab);
      m_done = 0;
      if (m_left > 0) begin
         if (ab) m_left = 0;
         else if (m_left == 1) begin
            m_left = 0;
            m_done = 1;
            if (p_wr) begin m_hi = p_hi; m_lo = p_lo; end
         end else m_left--;
      end else if (s && !ab) model_issue(o, a, b);
   endtask

   // One clock cycle: drive inputs, check outputs mid-cycle, advance model on the edge
   task automatic cyc(input bit s, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input bit ab, input bit md);
      start = s; op = o; rs_val = a; rt_val = b; abort = ab; md_use_id = md;
      #3;
      check("busy",  32'(busy),      32'(m_left > 0));
      check("done",  32'(done),      32'(m_done));
      check("hi",    hi,             m_hi);
      check("lo",    lo,             m_lo);
      check("stall", 32'(stall_req), 32'(md && ((m_left > 0) || (s && o <= 3'd3))));
      @(posedge clk);
      model_edge(s, o, a, b, ab);
      #1;
   endtask

   task automatic idle(input int n, input bit md);
      for (int i = 0; i < n; i++) cyc(0, 3'd0, 32'd0, 32'd0, 0, md);
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst = 1'b1; start = 0; op = 0; rs_val = 0; rt_val = 0; abort = 0; md_use_id = 0;
      model_reset();
      p_hi = 0; p_lo = 0; p_wr = 0;
      #12;
      check("rst_hi",   hi,         32'd0);
      check("rst_lo",   lo,         32'd0);
      check("rst_busy", 32'(busy),  32'd0);
      check("rst_done", 32'(done),  32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // mult with hazard held, plus an ignored start mid-operation
      cyc(1, 3'd0, 32'hFFFF_FFFF, 32'h2, 0, 1);
      cyc(0, 3'd0, 32'd0, 32'd0, 0, 1);
      cyc(1, 3'd0, 32'h1234, 32'h5678, 0, 1);
      idle(3, 1);
      check("mult_hi",   hi,        32'hFFFF_FFFF);
      check("mult_lo",   lo,        32'hFFFF_FFFE);
      check("mult_done", 32'(done), 32'd1);
      idle(2, 1);

      cyc(1, 3'd1, 32'hFFFF_FFFF, 32'h2, 0, 0);
      idle(MC, 0);
      check("multu_hi", hi, 32'h0000_0001);
      check("multu_lo", lo, 32'hFFFF_FFFE);

      cyc(1, 3'd2, 32'hFFFF_FFF9, 32'h2, 0, 0);
      idle(DC, 0);
      check("div_hi", hi, 32'hFFFF_FFFF);
      check("div_lo", lo, 32'hFFFF_FFFD);
      cyc(1, 3'd3, 32'h55, 32'h0, 0, 0);
      idle(DC, 0);
      check("divz_hi",   hi,        32'hFFFF_FFFF);
      check("divz_lo",   lo,        32'hFFFF_FFFD);
      check("divz_done", 32'(done), 32'd1);

      // mthi / mtlo back to back, hazard requested but no stall expected
      cyc(1, 3'd4, 32'h1234_5678, 32'd0, 0, 1);
      cyc(1, 3'd5, 32'h9ABC_DEF0, 32'd0, 0, 1);
      check("mthi", hi, 32'h1234_5678);
      check("mtlo", lo, 32'h9ABC_DEF0);
      idle(1, 1);

      // div overflow corner
      cyc(1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      idle(DC, 0);
      check("ovf_lo", lo, 32'h8000_0000);
      check("ovf_hi", hi, 32'd0);

      // abort on the third busy cycle of a div
      cyc(1, 3'd4, 32'hAAAA_0001, 32'd0, 0, 0);
      cyc(1, 3'd5, 32'hBBBB_0002, 32'd0, 0, 0);
      cyc(1, 3'd3, 32'd100, 32'd7, 0, 0);
      idle(2, 0);
      cyc(0, 3'd0, 32'd0, 32'd0, 1, 0);
      check("abort_busy", 32'(busy), 32'd0);
      idle(DC + 1, 0);
      check("abort_hi", hi, 32'hAAAA_0001);
      check("abort_lo", lo, 32'hBBBB_0002);

      // start with abort in idle: nothing happens
      cyc(1, 3'd4, 32'hDEAD_BEEF, 32'd0, 1, 1);
      cyc(1, 3'd0, 32'd3, 32'd3, 1, 0);
      idle(2, 0);
      check("sa_hi", hi, 32'hAAAA_0001);

      // random traffic
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(),
             $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);

      // asynchronous reset in the middle of a mult
      cyc(1, 3'd4, 32'h0F0F_0F0F, 32'd0, 0, 0);
      cyc(1, 3'd0, 32'd9, 32'd9, 0, 0);
      idle(2, 0);
      #2 rst = 1'b1;
      #1;
      check("arst_hi",   hi,        32'd0);
      check("arst_lo",   lo,        32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      model_reset();
      #2 rst = 1'b0;
      @(posedge clk); #1;
      idle(MC + 1, 0);
      check("post_rst_lo", lo, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide controller that owns the HI/LO register pair used by the pipeline's HILO path.
- The EX stage issues mult/multu/div/divu/mthi/mtlo through this block.
- The block sequences the fixed-latency operation and drives hi/lo to the EX/MEM → MEM/WB HILO path.
- The block generates the stall request the hazard unit uses to hold any HI/LO-using instruction in ID.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range ≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range ≥1)

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  valid MD instruction in EX this cycle
- op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6/7=reserved (no-op)
- rs_val  input  32  operand A / mthi-mtlo source
- rt_val  input  32  operand B
- abort  input  1  exception flush; cancels in-flight operation
- md_use_id  input  1  instruction in ID reads or writes HI/LO
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO take a mult/div result
- stall_req  output  1  stall request to the hazard unit
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - state=IDLE, cnt=0, busy=0, done=0, hi=0, lo=0.
  - Latched operands are discarded.
- States:
  - IDLE, BUSY.
  - cnt is a counter wide enough for max(MULT_CYCLES, DIV_CYCLES)-1.
- IDLE, start=1, abort=0, op 0..3:
  - On the edge, latch rs_val, rt_val and op.
  - Load cnt = N-1, where N = MULT_CYCLES or DIV_CYCLES.
  - Enter BUSY; busy=1 from the next cycle.
- IDLE, start=1, abort=0, op 4/5:
  - hi (op 4) or lo (op 5) takes rs_val on that edge.
  - No busy; done stays 0.
- IDLE, op 6/7: no effect.
- BUSY, per edge:
  - abort=1: go to IDLE; hi/lo unchanged; done=0.
  - Otherwise, cnt≠0: decrement cnt.
  - Otherwise, cnt=0: write result to hi/lo, go to IDLE, busy=0, done=1 for exactly one cycle.
- Latency and visibility:
  - busy is high for exactly N cycles.
  - New hi/lo are visible in the cycle busy falls.
- start while BUSY: ignored. stall_req guarantees this does not occur in a correct pipeline.
- start together with abort in IDLE: abort wins; nothing latched, hi/lo unchanged.
- Arithmetic (64-bit product; quotient/remainder computed from the latched operands):
  - mult: signed 32×32 product; hi=[63:32], lo=[31:0].
  - multu: unsigned 32×32 product; hi=[63:32], lo=[31:0].
  - div: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - div with 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divisor zero (div or divu): full DIV_CYCLES elapse, done pulses, hi/lo unchanged.
- stall_req is combinational: stall_req = md_use_id & (busy | (start & op≤3)).
  - Asserts in the issue cycle.
  - Holds through the final busy cycle.
  - Drops in the cycle busy falls.
- Outputs hi, lo, busy and done are registered.

Test Plan:
- mult, rs=0xFFFFFFFF, rt=0x00000002:
  - busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - done pulses once.
- multu, same operands → hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- div, rs=0xFFFFFFF9 (-7), rt=2:
  - busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Follow with divu, rt=0 → after 10 cycles hi/lo still 0xFFFFFFFF/0xFFFFFFFD and done=1.
- mthi 0x12345678, then mtlo 0x9ABCDEF0, on consecutive cycles:
  - hi/lo update the edge after each.
  - busy stays 0.
  - stall_req=0 even with md_use_id=1.
- Hazard checks:
  - Issue mult with md_use_id=1 held → stall_req=1 from the issue cycle through 5 busy cycles, then 0.
  - A start (op=0) during busy does not alter cnt or the result.
- Abort and reset:
  - Assert abort at busy cycle 3 of div → IDLE next edge; hi/lo keep prior values; no done.
  - Separately, pulse rst mid-mult → hi=lo=0, busy=0 immediately, without waiting for a clock edge.
